// File: rtl/mor1kx_pic_ctrl_pkg.sv
// Shared SPR addresses, field widths and decode helpers for the mor1kx PIC.
package mor1kx_pic_ctrl_pkg;

  localparam logic [15:0] OR1K_SPR_PICMR_ADDR = 16'h4800;
  localparam logic [15:0] OR1K_SPR_PICSR_ADDR = 16'h4802;
  localparam logic [15:0] OR1K_SPR_PICTR_ADDR = 16'h4803;
  localparam int SPR_OFS_W = 11;
  localparam int IRQ_IDX_W = 5;

  typedef enum logic [1:0] {
    PIC_SEL_NONE = 2'd0,
    PIC_SEL_MR   = 2'd1,
    PIC_SEL_SR   = 2'd2,
    PIC_SEL_TR   = 2'd3
  } pic_sel_e;

  function automatic logic [31:0] low_mask(input int n);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int i = 0; i < 32; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic pic_sel_e decode_ofs(input logic [SPR_OFS_W-1:0] ofs);
    pic_sel_e sel;
    case (ofs)
      OR1K_SPR_PICMR_ADDR[SPR_OFS_W-1:0]: sel = PIC_SEL_MR;
      OR1K_SPR_PICSR_ADDR[SPR_OFS_W-1:0]: sel = PIC_SEL_SR;
      OR1K_SPR_PICTR_ADDR[SPR_OFS_W-1:0]: sel = PIC_SEL_TR;
      default:                            sel = PIC_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mor1kx_pic_prio_enc.sv
// Combinational lowest-set-bit encoder: o_idx is the smallest i with i_req[i] set.
module mor1kx_pic_prio_enc
  import mor1kx_pic_ctrl_pkg::*;
#(
  parameter int NUM_IRQS = 32
) (
  input  logic [NUM_IRQS-1:0]  i_req,
  output logic                 o_valid,
  output logic [IRQ_IDX_W-1:0] o_idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = {IRQ_IDX_W{1'b0}};
    for (int i = NUM_IRQS - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IRQ_IDX_W'(i);
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/mor1kx_pic_ctrl.sv
// Programmable interrupt controller with per-line level/edge trigger select (PICTR).
// Define MOR1KX_PIC_SYNC_EN to add a two-flop synchronizer on irq_i.
module mor1kx_pic_ctrl
  import mor1kx_pic_ctrl_pkg::*;
#(
  parameter int NUM_IRQS               = 32,
  parameter int OPTION_PIC_NMI_WIDTH   = 0,
  parameter int OPTION_PIC_TRIGGER_RST = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IRQS-1:0]  irq_i,
  input  logic                 spr_access_i,
  input  logic                 spr_we_i,
  input  logic [15:0]          spr_addr_i,
  input  logic [31:0]          spr_dat_i,
  output logic                 spr_bus_ack,
  output logic [31:0]          spr_dat_o,
  output logic [31:0]          spr_picmr_o,
  output logic [31:0]          spr_picsr_o,
  output logic                 irq_o,
  output logic [IRQ_IDX_W-1:0] irq_id_o
);

  localparam logic [31:0]         NMI_MASK32 = low_mask(OPTION_PIC_NMI_WIDTH);
  localparam logic [NUM_IRQS-1:0] NMI_MASK   = NMI_MASK32[NUM_IRQS-1:0];
  localparam logic [NUM_IRQS-1:0] TR_RST     =
    (OPTION_PIC_TRIGGER_RST != 0) ? {NUM_IRQS{1'b1}} : {NUM_IRQS{1'b0}};

  logic [NUM_IRQS-1:0]  r_picmr, r_picsr, r_pictr, r_hist;
  logic                 r_irq;
  logic [IRQ_IDX_W-1:0] r_irq_id;
  logic [NUM_IRQS-1:0]  w_irq, w_unmasked, w_wdat, w_w1c, w_edge_set, w_sr_next, w_pending;
  logic                 w_wr_mr, w_wr_sr, w_wr_tr, w_enc_valid;
  logic [IRQ_IDX_W-1:0] w_enc_idx;
  logic [31:0]          w_rd_dat;
  pic_sel_e             w_sel;
  logic                 w_unused_bits;

`ifdef MOR1KX_PIC_SYNC_EN
  logic [NUM_IRQS-1:0] r_sync1, r_sync2;

  // Two-flop synchronizer for asynchronous interrupt sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= {NUM_IRQS{1'b0}};
      r_sync2 <= {NUM_IRQS{1'b0}};
    end else begin
      r_sync1 <= irq_i;
      r_sync2 <= r_sync1;
    end
  end
  assign w_irq = r_sync2;
`else
  assign w_irq = irq_i;
`endif

  if (NUM_IRQS < 32) begin : g_unused_part
    assign w_unused_bits = &{1'b0, spr_addr_i[15:SPR_OFS_W], spr_dat_i[31:NUM_IRQS]};
  end else begin : g_unused_full
    assign w_unused_bits = &{1'b0, spr_addr_i[15:SPR_OFS_W]};
  end

  assign w_sel      = decode_ofs(spr_addr_i[SPR_OFS_W-1:0]);
  assign w_wdat     = spr_dat_i[NUM_IRQS-1:0];
  assign w_wr_mr    = spr_access_i & spr_we_i & (w_sel == PIC_SEL_MR);
  assign w_wr_sr    = spr_access_i & spr_we_i & (w_sel == PIC_SEL_SR);
  assign w_wr_tr    = spr_access_i & spr_we_i & (w_sel == PIC_SEL_TR);
  assign w_unmasked = w_irq & r_picmr;
  assign w_edge_set = w_unmasked & ~r_hist;
  assign w_w1c      = w_wr_sr ? w_wdat : {NUM_IRQS{1'b0}};
  // Edge lines: set beats write-1-clear; level lines simply follow the masked input.
  assign w_sr_next  = (r_pictr & (w_edge_set | (r_picsr & ~w_w1c))) | (~r_pictr & w_unmasked);
  assign w_pending  = r_picsr & r_picmr;

  // Mask, trigger mode, status and edge-history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_picmr <= NMI_MASK;
      r_pictr <= TR_RST;
      r_picsr <= {NUM_IRQS{1'b0}};
      r_hist  <= {NUM_IRQS{1'b0}};
    end else begin
      if (w_wr_mr) r_picmr <= w_wdat | NMI_MASK;
      if (w_wr_tr) r_pictr <= w_wdat;
      r_picsr <= w_sr_next;
      r_hist  <= w_unmasked;
    end
  end

  mor1kx_pic_prio_enc #(.NUM_IRQS(NUM_IRQS)) u_prio_enc (
    .i_req   (w_pending),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

  // Registered request and index; the index holds while nothing is pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq    <= 1'b0;
      r_irq_id <= {IRQ_IDX_W{1'b0}};
    end else begin
      r_irq <= w_enc_valid;
      if (w_enc_valid) r_irq_id <= w_enc_idx;
    end
  end

  // SPR read mux, zero-extended, zero when idle or unmapped.
  always_comb begin
    w_rd_dat = 32'h0000_0000;
    if (spr_access_i) begin
      case (w_sel)
        PIC_SEL_MR: w_rd_dat = 32'(r_picmr);
        PIC_SEL_SR: w_rd_dat = 32'(r_picsr);
        PIC_SEL_TR: w_rd_dat = 32'(r_pictr);
        default:    w_rd_dat = 32'h0000_0000;
      endcase
    end else begin
      w_rd_dat = 32'h0000_0000;
    end
  end

  assign spr_bus_ack = spr_access_i;
  assign spr_dat_o   = w_rd_dat;
  assign spr_picmr_o = 32'(r_picmr);
  assign spr_picsr_o = 32'(r_picsr);
  assign irq_o       = r_irq;
  assign irq_id_o    = r_irq_id;

endmodule

// File: tb/tb_mor1kx_pic_ctrl.sv
// Scoreboard bench for mor1kx_pic_ctrl: a 32-line/2-NMI instance and an 8-line instance.
module tb_mor1kx_pic_ctrl;

  localparam int K_RD = 0, K_ACK = 1, K_IRQ = 2, K_ID = 3, K_SR = 4, K_MR = 5;
  localparam int K_RD8 = 6, K_ACK8 = 7, K_MR8 = 8;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] want;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] irq = 32'h0;
  logic        acc = 1'b0, we = 1'b0;
  logic [15:0] addr = 16'h0;
  logic [31:0] wdat = 32'h0;
  logic        ack;
  logic [31:0] rdat, picmr, picsr;
  logic        irq_o;
  logic [4:0]  irq_id;

  logic [7:0]  irq8 = 8'h0;
  logic        acc8 = 1'b0, we8 = 1'b0;
  logic [15:0] addr8 = 16'h0;
  logic [31:0] wdat8 = 32'h0;
  logic        ack8, irq_o8;
  logic [31:0] rdat8, picmr8, picsr8;
  logic [4:0]  irq_id8;

  sb_t sb_q[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mor1kx_pic_ctrl #(.NUM_IRQS(32), .OPTION_PIC_NMI_WIDTH(2), .OPTION_PIC_TRIGGER_RST(0)) u_dut (
    .clk(clk), .rst(rst), .irq_i(irq), .spr_access_i(acc), .spr_we_i(we),
    .spr_addr_i(addr), .spr_dat_i(wdat), .spr_bus_ack(ack), .spr_dat_o(rdat),
    .spr_picmr_o(picmr), .spr_picsr_o(picsr), .irq_o(irq_o), .irq_id_o(irq_id)
  );

  mor1kx_pic_ctrl #(.NUM_IRQS(8), .OPTION_PIC_NMI_WIDTH(0), .OPTION_PIC_TRIGGER_RST(0)) u_dut8 (
    .clk(clk), .rst(rst), .irq_i(irq8), .spr_access_i(acc8), .spr_we_i(we8),
    .spr_addr_i(addr8), .spr_dat_i(wdat8), .spr_bus_ack(ack8), .spr_dat_o(rdat8),
    .spr_picmr_o(picmr8), .spr_picsr_o(picsr8), .irq_o(irq_o8), .irq_id_o(irq_id8)
  );

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_RD:    return rdat;
      K_ACK:   return {31'h0, ack};
      K_IRQ:   return {31'h0, irq_o};
      K_ID:    return {27'h0, irq_id};
      K_SR:    return picsr;
      K_MR:    return picmr;
      K_RD8:   return rdat8;
      K_ACK8:  return {31'h0, ack8};
      K_MR8:   return picmr8;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: compare every scoreboard entry that falls due in this cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        n_vec++;
        if (sb_q[i].cyc < cyc || actual(sb_q[i].kind) !== sb_q[i].want) begin
          n_err++;
          $display("FAIL %s: got %h, want %h (cycle %0d, due %0d)", sb_q[i].name,
                   actual(sb_q[i].kind), sb_q[i].want, cyc, sb_q[i].cyc);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic sb_push(input string name, input int kind, input logic [31:0] want, input int dly);
    sb_t e;
    e.name = name; e.kind = kind; e.want = want; e.cyc = cyc + dly;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spr_wr(input logic [15:0] a, input logic [31:0] d);
    acc = 1'b1; we = 1'b1; addr = a; wdat = d;
    tick();
    acc = 1'b0; we = 1'b0;
  endtask

  task automatic spr_rd(input string name, input logic [15:0] a, input logic [31:0] want);
    acc = 1'b1; we = 1'b0; addr = a;
    sb_push(name, K_RD, want, 0);
    sb_push({name, "_ack"}, K_ACK, 32'h1, 0);
    tick();
    acc = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    spr_rd("rst_picmr", 16'h4800, 32'h3);
    spr_rd("rst_picsr", 16'h4802, 32'h0);
    spr_rd("rst_pictr", 16'h4803, 32'h0);
    sb_push("rst_irq", K_IRQ, 32'h0, 0);
    sb_push("rst_id", K_ID, 32'h0, 0);
    spr_rd("unmapped_ofs1", 16'h4801, 32'h0);

    // Level mode on line 4
    spr_wr(16'h4800, 32'h10);
    sb_push("mr_nmi_kept", K_MR, 32'h13, 0);
    irq = 32'h10;
    sb_push("lvl_sr_t0", K_SR, 32'h0, 0);
    sb_push("lvl_sr_t1", K_SR, 32'h10, 1);
    sb_push("lvl_irq_t1", K_IRQ, 32'h0, 1);
    sb_push("lvl_irq_t2", K_IRQ, 32'h1, 2);
    sb_push("lvl_id_t2", K_ID, 32'h4, 2);
    repeat (3) tick();
    irq = 32'h0;
    sb_push("lvl_drop_irq1", K_IRQ, 32'h1, 1);
    sb_push("lvl_drop_sr1", K_SR, 32'h0, 1);
    sb_push("lvl_drop_irq2", K_IRQ, 32'h0, 2);
    sb_push("lvl_id_hold", K_ID, 32'h4, 3);
    repeat (4) tick();

    // Edge mode on line 8
    spr_wr(16'h4803, 32'h100);
    spr_wr(16'h4800, 32'h100);
    spr_rd("edge_pictr", 16'h4803, 32'h100);
    spr_rd("edge_picmr", 16'h4800, 32'h103);
    irq = 32'h100;
    sb_push("edge_sr_set", K_SR, 32'h100, 1);
    sb_push("edge_irq", K_IRQ, 32'h1, 2);
    sb_push("edge_id", K_ID, 32'h8, 2);
    sb_push("edge_sr_held", K_SR, 32'h100, 4);
    tick();
    irq = 32'h0;
    repeat (4) tick();
    sb_push("w1c_sr_before", K_SR, 32'h100, 0);
    sb_push("w1c_sr_after", K_SR, 32'h0, 1);
    sb_push("w1c_irq_1", K_IRQ, 32'h1, 1);
    sb_push("w1c_irq_2", K_IRQ, 32'h0, 2);
    sb_push("w1c_id_hold", K_ID, 32'h8, 3);
    spr_wr(16'h4802, 32'h100);
    repeat (3) tick();

    // Edge set coincident with write-1-clear, then clear while line stays high
    irq = 32'h100;
    sb_push("set_wins", K_SR, 32'h100, 1);
    spr_wr(16'h4802, 32'h100);
    sb_push("no_retrigger", K_SR, 32'h0, 1);
    sb_push("coin_irq_1", K_IRQ, 32'h1, 1);
    sb_push("coin_irq_2", K_IRQ, 32'h0, 2);
    spr_wr(16'h4802, 32'h100);
    irq = 32'h0;
    repeat (3) tick();

    // Priority: line 3 edge, lines 7 and 12 level
    spr_wr(16'h4803, 32'h8);
    spr_wr(16'h4800, 32'hFFFF);
    irq = 32'h1088;
    sb_push("prio_sr", K_SR, 32'h1088, 1);
    sb_push("prio_irq", K_IRQ, 32'h1, 2);
    sb_push("prio_id3", K_ID, 32'h3, 2);
    repeat (2) tick();
    irq = 32'h1080;
    sb_push("prio_edge_held", K_SR, 32'h1088, 1);
    repeat (2) tick();
    sb_push("prio_w1c_sr", K_SR, 32'h1080, 1);
    sb_push("prio_irq_stays", K_IRQ, 32'h1, 2);
    sb_push("prio_id7", K_ID, 32'h7, 2);
    spr_wr(16'h4802, 32'h1088);
    repeat (3) tick();

    // Reset mid-operation
    sb_push("pre_rst_irq", K_IRQ, 32'h1, 0);
    rst = 1'b1;
    sb_push("mid_rst_sr", K_SR, 32'h0, 1);
    sb_push("mid_rst_mr", K_MR, 32'h3, 1);
    sb_push("mid_rst_irq", K_IRQ, 32'h0, 1);
    sb_push("mid_rst_id", K_ID, 32'h0, 1);
    tick();
    rst = 1'b0;
    sb_push("post_rst_sr", K_SR, 32'h0, 1);
    sb_push("post_rst_irq", K_IRQ, 32'h0, 2);
    spr_rd("post_rst_pictr", 16'h4803, 32'h0);
    irq = 32'h0;
    repeat (2) tick();

    // Eight-line instance: unimplemented bits, unmapped offset, idle bus
    acc8 = 1'b1; we8 = 1'b1; addr8 = 16'h4800; wdat8 = 32'hFFFF_FFFF;
    tick();
    we8 = 1'b0;
    sb_push("n8_picmr_rd", K_RD8, 32'hFF, 0);
    sb_push("n8_picmr_o", K_MR8, 32'hFF, 0);
    tick();
    addr8 = 16'h4805;
    sb_push("n8_unmapped", K_RD8, 32'h0, 0);
    sb_push("n8_unmapped_ack", K_ACK8, 32'h1, 0);
    tick();
    acc8 = 1'b0; addr8 = 16'h4800;
    sb_push("n8_idle_dat", K_RD8, 32'h0, 0);
    sb_push("n8_idle_ack", K_ACK8, 32'h0, 0);
    tick();

    for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d checks never reached, want 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
